// File: rtl/csa_pkg.sv
// rtl/csa_pkg.sv - state type and counter sizing shared by the csa_resolve stage
package csa_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic int cnt_width(input int width, input int chunk);
    int n;
    n = width / chunk;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/csa_chunk_add.sv
// rtl/csa_chunk_add.sv - CHUNK-bit adder with carry in/out, kept as a single + so it maps onto the carry chain
module csa_chunk_add #(
  parameter int CHUNK = 64
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/csa_resolve.sv
// rtl/csa_resolve.sv - resolves a (sum, carry) row pair to binary CHUNK bits per cycle; CSA_RESOLVE_B2B_EN enables back-to-back accept
module csa_resolve
  import csa_pkg::*;
#(
  parameter int WIDTH = 256,
  parameter int CHUNK = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_cy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_cout,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW = cnt_width(WIDTH, CHUNK);
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  if (WIDTH % CHUNK != 0) begin : g_bad_width
    $error("csa_resolve: WIDTH must be an integer multiple of CHUNK");
  end

  state_t           state, state_nxt;
  logic [WIDTH-1:0] op_sum, op_cy;
  logic [KW-1:0]    k;
  logic             carry_reg;
  logic [CHUNK-1:0] sum_k, cy_k, chunk_sum;
  logic             chunk_cout;
  logic             accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (k == K_LAST) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
`ifdef CSA_RESOLVE_B2B_EN
        // the consumer taking the result frees the stage for a new pair on the same edge
        in_ready = out_ready;
        if (out_ready) state_nxt = in_valid ? RUN : IDLE;
`else
        if (out_ready) state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    sum_k = '0;
    cy_k  = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (k == KW'(i)) begin
        sum_k = op_sum[i*CHUNK +: CHUNK];
        cy_k  = op_cy[i*CHUNK +: CHUNK];
      end
    end
  end

  csa_chunk_add #(.CHUNK(CHUNK)) u_add (
    .a    (sum_k),
    .b    (cy_k),
    .cin  (carry_reg),
    .sum  (chunk_sum),
    .cout (chunk_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_sum    <= '0;
      op_cy     <= '0;
      k         <= '0;
      carry_reg <= 1'b0;
      out_data  <= '0;
      out_cout  <= 1'b0;
    end else if (accept) begin
      op_sum    <= in_sum;
      op_cy     <= in_cy;
      k         <= '0;
      carry_reg <= 1'b0;
    end else if (state == RUN) begin
      for (int i = 0; i < NCHUNK; i++) begin
        if (k == KW'(i)) out_data[i*CHUNK +: CHUNK] <= chunk_sum;
      end
      carry_reg <= chunk_cout;
      // k parks on the last chunk; the next accept clears it
      if (k == K_LAST) out_cout <= chunk_cout;
      else             k <= k + 1'b1;
    end
  end

endmodule

// File: tb/tb_csa_resolve.sv
// tb/tb_csa_resolve.sv - self-checking bench for csa_resolve: vector table, corner sequences, random scoreboard
module tb_csa_resolve;

  localparam int WIDTH  = 256;
  localparam int CHUNK  = 64;
  localparam int NCHUNK = WIDTH / CHUNK;
`ifdef CSA_RESOLVE_B2B_EN
  localparam int PERIOD = NCHUNK + 1;
`else
  localparam int PERIOD = NCHUNK + 2;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_sum = '0;
  logic [WIDTH-1:0] in_cy = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_cout;
  logic             busy;

  csa_resolve #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_cy     (in_cy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic             co;
  } vec_t;

  task automatic chk(input string name, input logic [WIDTH:0] act, input logic [WIDTH:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [WIDTH-1:0] rnd();
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // biased carry rows so long ripple chains across chunk boundaries are common
  function automatic logic [WIDTH-1:0] rnd_cy(input logic [WIDTH-1:0] s);
    case ($urandom_range(3))
      0:       return rnd();
      1:       return ~s;
      2:       return ~s + WIDTH'(1);
      default: return WIDTH'($urandom);
    endcase
  endfunction

  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c);
    return {1'b0, s} + {1'b0, c};
  endfunction

  // called at a negedge with the stage idle; returns at the negedge where out_valid is first seen
  task automatic issue(input vec_t v, input bit check_run, output int lat);
    chk({v.name, " in_ready idle"}, in_ready, 1);
    in_valid = 1'b1;
    in_sum   = v.s;
    in_cy    = v.c;
    @(negedge clk);
    in_valid = 1'b0;
    in_sum   = rnd();
    in_cy    = rnd();
    lat = 0;
    while (!out_valid && lat <= 20) begin
      if (check_run) begin
        chk({v.name, " busy in run"}, busy, 1);
        chk({v.name, " in_ready in run"}, in_ready, 0);
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v, input bit check_run);
    int lat;
    issue(v, check_run, lat);
    chk({v.name, " latency"}, lat, NCHUNK);
    chk({v.name, " data"}, out_data, v.d);
    chk({v.name, " cout"}, out_cout, v.co);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({v.name, " valid drops"}, out_valid, 0);
  endtask

  vec_t vecs[7];
  vec_t v;
  logic [WIDTH-1:0] ones;
  logic [WIDTH-1:0] ps[3], pc[3];
  logic [WIDTH:0]   q[$];
  logic [WIDTH-1:0] pend_s, pend_c;
  logic [WIDTH-1:0] held;
  int lat, idx, got, last_t, sent, recv, extra;

  initial begin
    ones = '1;
    vecs[0] = '{"ones_plus_one", ones, WIDTH'(1), '0, 1'b1};
    vecs[1] = '{"small", WIDTH'(16'h1234), WIDTH'(16'h0FFF), WIDTH'(16'h2233), 1'b0};
    vecs[2] = '{"zero", '0, '0, '0, 1'b0};
    vecs[3] = '{"ones_plus_ones", ones, ones, {{(WIDTH-1){1'b1}}, 1'b0}, 1'b1};
    vecs[4] = '{"chunk_boundary", WIDTH'(64'hFFFF_FFFF_FFFF_FFFF), WIDTH'(1), WIDTH'(1) << 64, 1'b0};
    vecs[5] = '{"no_carry_mix", {64{4'hA}}, {64{4'h5}}, ones, 1'b0};
    vecs[6] = '{"top_bit_overflow", WIDTH'(1) << (WIDTH-1), WIDTH'(1) << (WIDTH-1), '0, 1'b1};

    // reset state
    repeat (2) @(negedge clk);
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset out_data", out_data, 0);
    chk("reset out_cout", out_cout, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i == 1);

    // result held while the consumer stalls; in_valid pulses must not be taken
    issue(vecs[1], 1'b0, lat);
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      in_valid  = (i % 2 == 0);
      in_sum    = rnd();
      in_cy     = rnd();
      out_ready = 1'b0;
      #1;
      chk("stall out_valid", out_valid, 1);
      chk("stall out_data", out_data, held);
      chk("stall in_ready", in_ready, 0);
      @(negedge clk);
    end
    chk("stall data value", held, WIDTH'(16'h2233));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("stall drained valid", out_valid, 0);
    chk("stall no accept busy", busy, 0);
    chk("stall idle in_ready", in_ready, 1);

    // asynchronous reset in the second RUN cycle
    in_valid = 1'b1;
    in_sum   = ones;
    in_cy    = ones;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("abort busy before reset", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort in_ready", in_ready, 1);
    chk("abort out_valid", out_valid, 0);
    chk("abort busy", busy, 0);
    chk("abort out_data", out_data, 0);
    chk("abort out_cout", out_cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    v = '{"after_abort_5_plus_3", WIDTH'(5), WIDTH'(3), WIDTH'(8), 1'b0};
    run_vec(v, 1'b0);

    // streaming: in_valid and out_ready held high with three queued pairs
    for (int i = 0; i < 3; i++) begin
      ps[i] = rnd();
      pc[i] = rnd_cy(ps[i]);
    end
    idx = 0; got = 0; last_t = 0;
    for (int cyc = 0; cyc < 80 && got < 3; cyc++) begin
      in_valid = (idx < 3);
      if (idx < 3) begin
        in_sum = ps[idx];
        in_cy  = pc[idx];
      end
      out_ready = 1'b1;
      #1;
      if (out_valid) begin
        chk("stream result", {out_cout, out_data}, model(ps[got], pc[got]));
        if (got > 0) chk("stream period", cyc - last_t, PERIOD);
        last_t = cyc;
        got++;
      end
      if (in_valid && in_ready) idx++;
      @(negedge clk);
    end
    chk("stream result count", got, 3);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);

    // random traffic with stalls on both sides against the scoreboard
    pend_s = rnd();
    pend_c = rnd_cy(pend_s);
    sent = 0; recv = 0; extra = 0;
    for (int cyc = 0; cyc < 40000 && recv < 1000; cyc++) begin
      in_valid  = (sent < 1000) && ($urandom_range(3) != 0);
      in_sum    = pend_s;
      in_cy     = pend_c;
      out_ready = ($urandom_range(9) < 7);
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) extra++;
        else chk("rand result", {out_cout, out_data}, q.pop_front());
        recv++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(pend_s, pend_c));
        sent++;
        pend_s = rnd();
        pend_c = rnd_cy(pend_s);
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("rand received", recv, 1000);
    chk("rand unexpected results", extra, 0);
    chk("rand leftover", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
